// File: rtl/guess_input_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | guess_input_ctrl: synchronizes and debounces confirm, validates the BCD    |
// | guess on SW and offers it to the game FSM over a valid/ready handshake.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module guess_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CHECK_DISTINCT  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] SW,
  input  logic        confirm,
  input  logic        guess_ready,
  output logic [15:0] guess,
  output logic        guess_valid,
  output logic        guess_error,
  output logic        press_dropped
);

  localparam logic [0:0]  c_idle    = 1'b0;
  localparam logic [0:0]  c_offer   = 1'b1;
  localparam logic [23:0] c_cnt_max = 24'(DEBOUNCE_CYCLES - 1);

  logic [15:0] r_sw_meta, r_sw_sync;
  logic        r_conf_meta, r_conf_sync;
  logic        r_stable, r_stable_d, r_press;
  logic [23:0] r_cnt;
  logic [0:0]  r_state;
  logic [15:0] r_guess;
  logic        r_error, r_dropped;

  logic [3:0]  w_digit [4];
  logic        w_in_range, w_distinct, w_sw_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sw_meta   <= 16'h0000;
      r_sw_sync   <= 16'h0000;
      r_conf_meta <= 1'b0;
      r_conf_sync <= 1'b0;
    end else begin
      r_sw_meta   <= SW;
      r_sw_sync   <= r_sw_meta;
      r_conf_meta <= confirm;
      r_conf_sync <= r_conf_meta;
    end
  end

  // The press pulse is registered once more so the FSM sees it a full cycle
  // after the stable level rises.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_press    <= 1'b0;
      r_cnt      <= 24'd0;
    end else begin
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      if (r_conf_sync == r_stable) begin
        r_cnt <= 24'd0;
      end else if (r_cnt == c_cnt_max) begin
        r_stable <= ~r_stable;
        r_cnt    <= 24'd0;
      end else begin
        r_cnt <= r_cnt + 24'd1;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign w_digit[gi] = r_sw_sync[15-4*gi -: 4];
  end

  always_comb begin
    w_in_range = 1'b1;
    w_distinct = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_digit[i] > 4'd9) w_in_range = 1'b0;
      for (int j = i + 1; j < 4; j++) begin
        if (w_digit[i] == w_digit[j]) w_distinct = 1'b0;
      end
    end
    w_sw_ok = w_in_range & (w_distinct | (CHECK_DISTINCT == 0));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= c_idle;
      r_guess   <= 16'h0000;
      r_error   <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_error   <= 1'b0;
      r_dropped <= 1'b0;
      case (r_state)
        c_idle: begin
          if (r_press) begin
            if (w_sw_ok) begin
              r_state <= c_offer;
              r_guess <= r_sw_sync;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        c_offer: begin
          if (r_press)     r_dropped <= 1'b1;
          if (guess_ready) r_state   <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign guess         = r_guess;
  assign guess_valid   = (r_state == c_offer);
  assign guess_error   = r_error;
  assign press_dropped = r_dropped;

endmodule
`default_nettype wire
